// File: rtl/average_datapath_if.sv
// ---------------------------------------------------------------------------
// average_datapath_if
//
// Purpose: groups the strobes, sample bus and result signals exchanged
// between the averaging controller (master) and the accumulating datapath
// (slave).
//
// Parameters:
//   W     sample and result width in bits
//   LOGN  log2 of the batch size
//
// Signals:
//   init        clear strobe (controller -> datapath)
//   ld          load/accumulate strobe (controller -> datapath)
//   data_in     unsigned sample, W bits (controller -> datapath)
//   co          batch complete flag (datapath -> controller)
//   avg         rounded mean of the last completed batch, W bits
//   sample_cnt  samples accumulated in the current batch, LOGN bits
// ---------------------------------------------------------------------------
interface average_datapath_if #(
  parameter int W    = 8,
  parameter int LOGN = 3
);

  logic            init;
  logic            ld;
  logic [W-1:0]    data_in;
  logic            co;
  logic [W-1:0]    avg;
  logic [LOGN-1:0] sample_cnt;

  modport master (
    output init,
    output ld,
    output data_in,
    input  co,
    input  avg,
    input  sample_cnt
  );

  modport slave (
    input  init,
    input  ld,
    input  data_in,
    output co,
    output avg,
    output sample_cnt
  );

endinterface

// File: rtl/average_datapath.sv
// ---------------------------------------------------------------------------
// average_datapath
//
// Purpose: accumulates a batch of N = 2^LOGN unsigned samples and produces
// their round-half-up mean. Driven by the averaging controller through the
// init/ld strobes; returns the batch-complete flag co.
//
// Parameters:
//   W     sample and result width in bits (default 8)
//   LOGN  log2 of the batch size, legal range 1..8 (default 3)
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous, active-low reset
//   dp    slave side of average_datapath_if:
//           init, ld, data_in in; co, avg, sample_cnt out (all registered)
//
// Priority per edge: reset > init > ld > hold.
// ---------------------------------------------------------------------------
module average_datapath #(
  parameter int W    = 8,
  parameter int LOGN = 3
) (
  input  logic               clk,
  input  logic               rst,
  average_datapath_if.slave  dp
);

  localparam int N = 1 << LOGN;
  localparam int SUM_W = W + LOGN;

  // Index of the last sample in a batch; reaching it closes the batch.
  localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);

  // Half an LSB of the result, added before the shift for round-half-up.
  localparam logic [SUM_W-1:0] HALF = SUM_W'(N / 2);

  logic [SUM_W-1:0] acc;
  logic [LOGN-1:0]  cnt;
  logic [W-1:0]     avg_q;
  logic             co_q;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] rounded;
  logic [W-1:0]     avg_next;

  // The running sum plus the incoming sample. At SUM_W bits it cannot
  // overflow: N*(2^W-1) + N/2 < N*2^W, so even the rounded full-scale sum
  // fits and the shifted result is at most 2^W-1.
  always_comb begin
    sum      = acc + SUM_W'(dp.data_in);
    rounded  = sum + HALF;
    avg_next = W'(rounded >> LOGN);
  end

  // Accumulator, sample counter and result registers. The counter wraps to
  // zero on the N-th sample, so an ld while co is high naturally starts a
  // fresh batch as sample 1 and clears co.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      avg_q <= '0;
      co_q  <= 1'b0;
    end else if (dp.init) begin
      acc  <= '0;
      cnt  <= '0;
      co_q <= 1'b0;
    end else if (dp.ld) begin
      if (cnt == CNT_LAST) begin
        avg_q <= avg_next;
        acc   <= '0;
        cnt   <= '0;
        co_q  <= 1'b1;
      end else begin
        acc  <= sum;
        cnt  <= cnt + LOGN'(1);
        co_q <= 1'b0;
      end
    end
  end

  assign dp.co         = co_q;
  assign dp.avg        = avg_q;
  assign dp.sample_cnt = cnt;

endmodule

// File: tb/tb_average_datapath.sv
// ---------------------------------------------------------------------------
// tb_average_datapath
//
// Purpose: directed, self-checking bench for average_datapath (W=8, LOGN=3).
// Each stimulus cycle carries hand-computed expected outputs that are queued
// and later compared by an independent monitor after the clock edge.
// ---------------------------------------------------------------------------
module tb_average_datapath;

  typedef struct {
    logic       co;
    logic [7:0] avg;
    logic [2:0] cnt;
  } exp_t;

  logic clk;
  logic rst;

  exp_t expQ[$];
  int   checks;
  int   errors;

  average_datapath_if #(.W(8), .LOGN(3)) bus ();

  average_datapath #(.W(8), .LOGN(3)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: after every rising edge the DUT's registered outputs are
  // compared against the expectation queued for that edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks = checks + 1;
      if (bus.co !== e.co) begin
        errors = errors + 1;
        $display("[TB] FAIL co: got %0b expected %0b at %0t", bus.co, e.co, $time);
      end
      checks = checks + 1;
      if (bus.avg !== e.avg) begin
        errors = errors + 1;
        $display("[TB] FAIL avg: got %0d expected %0d at %0t", bus.avg, e.avg, $time);
      end
      checks = checks + 1;
      if (bus.sample_cnt !== e.cnt) begin
        errors = errors + 1;
        $display("[TB] FAIL sample_cnt: got %0d expected %0d at %0t", bus.sample_cnt, e.cnt, $time);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input logic r, input logic i, input logic l,
                               input logic [7:0] d, input logic expCo,
                               input logic [7:0] expAvg, input logic [2:0] expCnt);
    exp_t e;
    @(negedge clk);
    #1;
    rst         = r;
    bus.init    = i;
    bus.ld      = l;
    bus.data_in = d;
    e.co  = expCo;
    e.avg = expAvg;
    e.cnt = expCnt;
    expQ.push_back(e);
  endtask

  // Load eight samples back to back; prevAvg is held until the eighth edge,
  // which produces expAvg with co raised and the counter wrapped.
  task automatic runBatch(input logic [7:0] s[8], input logic [7:0] prevAvg,
                          input logic [7:0] expAvg);
    for (int k = 0; k < 8; k++) begin
      if (k == 7)
        applyStimulus(1'b1, 1'b0, 1'b1, s[k], 1'b1, expAvg, 3'd0);
      else
        applyStimulus(1'b1, 1'b0, 1'b1, s[k], 1'b0, prevAvg, 3'(k + 1));
    end
  endtask

  task automatic checkOutput();
    // Let the monitor drain the final expectation.
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [7:0] s[8];

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.init    = 1'b0;
    bus.ld      = 1'b0;
    bus.data_in = 8'h00;

    // Reset for two edges while ld and a full-scale sample are presented.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'd0, 3'd0);

    // Basic batch of 10s, then an idle cycle where co and avg hold.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 3'd0);
    s = '{8{8'd10}};
    runBatch(s, 8'd0, 8'd10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd99, 1'b1, 8'd10, 3'd0);

    // Rounding: 0..7 sums to 28, (28+4)>>3 = 4.
    s = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    runBatch(s, 8'd10, 8'd4);
    // Exactly half rounds up: (4+4)>>3 = 1.
    s = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4};
    runBatch(s, 8'd4, 8'd1);
    // Below half rounds down: (3+4)>>3 = 0.
    s = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3};
    runBatch(s, 8'd1, 8'd0);

    // Full scale must not wrap: (2040+4)>>3 = 255.
    s = '{8{8'd255}};
    runBatch(s, 8'd0, 8'd255);

    // Abort: three samples of 200, then init together with ld wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd200, 1'b0, 8'd255, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd200, 1'b0, 8'd255, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd200, 1'b0, 8'd255, 3'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd200, 1'b0, 8'd255, 3'd0);
    s = '{8{8'd1}};
    runBatch(s, 8'd255, 8'd1);

    // Full-scale zero batch.
    s = '{8{8'd0}};
    runBatch(s, 8'd1, 8'd0);

    // Back-to-back: ld held for 16 cycles, 8 x 20 then 8 x 40.
    s = '{8{8'd20}};
    runBatch(s, 8'd0, 8'd20);
    s = '{8{8'd40}};
    runBatch(s, 8'd20, 8'd40);

    // Reset mid-batch discards the partial sum and clears avg.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd50, 1'b0, 8'd40, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd50, 1'b0, 8'd40, 3'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd50, 1'b0, 8'd0, 3'd0);
    s = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd8};
    runBatch(s, 8'd0, 8'd7);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd7, 3'd0);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/average_datapath.md
# average_datapath

Accumulating datapath for the averaging circuit: sums a batch of N = 2^LOGN unsigned samples and produces their rounded mean. It sits directly downstream of the averaging controller. The controller's `init` and `ld` strobes drive this block, and this block returns the batch-complete flag `co` that the controller tests in its final state.

## Interface
Parameters:
- `W`, default 8: sample and result width in bits.
- `LOGN`, default 3: log2 of the batch size. N = 2^LOGN; legal range 1..8.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `init`  in  1  clear strobe from the controller.
- `ld`  in  1  load/accumulate strobe from the controller.
- `data_in`  in  W  unsigned sample; sampled on a rising edge when `ld`=1.
- `co`  out  1  batch complete; registered.
- `avg`  out  W  rounded mean of the last completed batch; registered.
- `sample_cnt`  out  LOGN  number of samples accumulated in the current batch; registered.

## Operation
- Internal state:
  - accumulator `acc`, W+LOGN bits, unsigned.
  - counter `cnt`, LOGN bits; drives `sample_cnt` directly.
  - registers `avg` and `co`.
- Priority per rising edge: `rst`=0 > `init` > `ld` > hold.
- Reset (`rst`=0 at an edge): `acc`=0, `cnt`=0, `avg`=0, `co`=0. `init`, `ld` and `data_in` are ignored on that edge.
- `init`=1 (regardless of `ld`):
  - `acc`←0, `cnt`←0, `co`←0.
  - `avg` holds its value.
- `ld`=1, `init`=0, `cnt`<N-1:
  - `acc`←`acc`+`data_in`, `cnt`←`cnt`+1.
  - `co`←0.
  - `avg` holds.
- `ld`=1, `init`=0, `cnt`=N-1 (the N-th sample):
  - `avg`←(`acc`+`data_in`+N/2) >> LOGN.
  - `acc`←0, `cnt`←0 (wraps), `co`←1.
- Arithmetic and widths:
  - The sum is formed at W+LOGN bits and never overflows: max N·(2^W−1)+N/2 < N·2^W.
  - The result fits in W bits, with max 2^W−1.
  - Rounding is round-half-up.
  - No saturation logic is required.
- `co` stays high, holding the completed `avg`, until the next `init` or `ld`. An `ld` while `co`=1 starts a new batch: that sample becomes sample 1 and `co`←0.
- Idle (`init`=0, `ld`=0): all registers hold.
- `ld` held high for consecutive cycles accumulates one sample per cycle. There is no edge detection.

## Timing
- All outputs are registered. Outputs reflect an edge's effect immediately after that edge. There is no combinational path from input to output.
- `co` and the new `avg` are valid in the cycle following the edge that captured the N-th `ld`. Latency from the last sample to the result is 1 cycle.
- Minimum batch time: N consecutive `ld` cycles, then `co` on cycle N+1.
- Reset values: `co`=0, `avg`=0, `sample_cnt`=0.
- Reset mid-batch discards the partial sum. The batch restarts from zero after `rst` returns high.
- `init` mid-batch discards the partial sum and keeps the previous `avg`.

## Test plan
- Reset: drive `rst`=0 for 2 edges with `ld`=1 and `data_in`=0xFF -> `co`=0, `avg`=0, `sample_cnt`=0.
- Basic batch (W=8, LOGN=3): `init`, then 8 `ld` cycles with `data_in`=10 -> `co`=1 one cycle after the 8th `ld`, `avg`=10, `sample_cnt`=0.
- Rounding:
  - Samples 0,1,…,7 -> sum 28, (28+4)>>3 -> `avg`=4.
  - Samples 0×7 then 4 -> (4+4)>>3 -> `avg`=1.
  - Samples 0×7 then 3 -> `avg`=0.
- Full scale: 8 × 255 -> `avg`=255 with no wrap. Then 8 × 0 -> `avg`=0.
- Abort and priority:
  - After 3 samples of 200, assert `init` and `ld` together -> `sample_cnt`=0 and `co`=0, with `avg` keeping its previous value.
  - Then 8 × 1 -> `avg`=1.
- Back-to-back batches: with `ld` held continuously for 16 cycles (8 × 20, then 8 × 40) -> `co` pulses for one cycle after edge 8 with `avg`=20. The 9th `ld` clears `co`. After edge 16, `co`=1 and `avg`=40.
